// File: rtl/sc_collision_scan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sc_collision_scan_pkg                                                |
// | Shared defaults, row-address sizing and FSM encoding for the scanner.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package sc_collision_scan_pkg;

  localparam int DEF_ROWS  = 8;
  localparam int DEF_WIDTH = 8;

  // A one-row field still needs a one-bit address bus.
  function automatic int addr_width(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  localparam int ROW_AW = addr_width(DEF_ROWS);

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SCAN = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/sc_collision_scan_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sc_collision_scan_if                                                 |
// | Row-read, merge-stream and frame-result signals of the scanner.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface sc_collision_scan_if
#(
  parameter int ROWS  = sc_collision_scan_pkg::DEF_ROWS,
  parameter int WIDTH = sc_collision_scan_pkg::DEF_WIDTH
);

  localparam int AW = sc_collision_scan_pkg::addr_width(ROWS);

  logic             SC_COLLISION_SCAN_start_InHigh;
  logic [WIDTH-1:0] SC_COLLISION_SCAN_pointRow_In;
  logic [WIDTH-1:0] SC_COLLISION_SCAN_backRow_In;
  logic [AW-1:0]    SC_COLLISION_SCAN_rowAddr_Out;
  logic [WIDTH-1:0] SC_COLLISION_SCAN_mergeRow_Out;
  logic             SC_COLLISION_SCAN_mergeValid_Out;
  logic [AW-1:0]    SC_COLLISION_SCAN_mergeAddr_Out;
  logic             SC_COLLISION_SCAN_busy_Out;
  logic             SC_COLLISION_SCAN_done_Out;
  logic             SC_COLLISION_SCAN_collision_Out;
  logic [AW-1:0]    SC_COLLISION_SCAN_hitRow_Out;

  // Controller / register-file side.
  modport master (
    output SC_COLLISION_SCAN_start_InHigh,
    output SC_COLLISION_SCAN_pointRow_In,
    output SC_COLLISION_SCAN_backRow_In,
    input  SC_COLLISION_SCAN_rowAddr_Out,
    input  SC_COLLISION_SCAN_mergeRow_Out,
    input  SC_COLLISION_SCAN_mergeValid_Out,
    input  SC_COLLISION_SCAN_mergeAddr_Out,
    input  SC_COLLISION_SCAN_busy_Out,
    input  SC_COLLISION_SCAN_done_Out,
    input  SC_COLLISION_SCAN_collision_Out,
    input  SC_COLLISION_SCAN_hitRow_Out
  );

  // Scanner side.
  modport slave (
    input  SC_COLLISION_SCAN_start_InHigh,
    input  SC_COLLISION_SCAN_pointRow_In,
    input  SC_COLLISION_SCAN_backRow_In,
    output SC_COLLISION_SCAN_rowAddr_Out,
    output SC_COLLISION_SCAN_mergeRow_Out,
    output SC_COLLISION_SCAN_mergeValid_Out,
    output SC_COLLISION_SCAN_mergeAddr_Out,
    output SC_COLLISION_SCAN_busy_Out,
    output SC_COLLISION_SCAN_done_Out,
    output SC_COLLISION_SCAN_collision_Out,
    output SC_COLLISION_SCAN_hitRow_Out
  );

endinterface
`default_nettype wire

// File: rtl/sc_collision_scan_row_merge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cc_row_merge                                                         |
// | Per-row display merge (OR) and collision detect (AND, then reduce).  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cc_row_merge
  import sc_collision_scan_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
)
(
  input  logic [WIDTH-1:0] point_row,
  input  logic [WIDTH-1:0] back_row,
  output logic [WIDTH-1:0] merge_row,
  output logic             hit
);

  logic [WIDTH-1:0] w_overlap;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign merge_row[i] = point_row[i] | back_row[i];
    assign w_overlap[i] = point_row[i] & back_row[i];
  end

  assign hit = |w_overlap;

endmodule
`default_nettype wire

// File: rtl/sc_collision_scan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sc_collision_scan                                                    |
// | Walks every playfield row once per start, streams merged rows and    |
// | reports whether, and at which lowest row, frog and background meet.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sc_collision_scan
  import sc_collision_scan_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int WIDTH = DEF_WIDTH
)
(
  input  logic                SC_COLLISION_SCAN_CLOCK_50,
  input  logic                SC_COLLISION_SCAN_RESET_InLow,
  sc_collision_scan_if.slave  bus
);

  localparam int              c_AW       = addr_width(ROWS);
  localparam logic [c_AW-1:0] c_LAST_ROW = c_AW'(ROWS - 1);
  localparam logic [c_AW-1:0] c_ONE      = c_AW'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [c_AW-1:0]  r_row;
  logic             r_acc;
  logic             r_hit_seen;
  logic [c_AW-1:0]  r_hit_row;
  logic [WIDTH-1:0] r_merge_row;
  logic [c_AW-1:0]  r_merge_addr;
  logic             r_merge_valid;
  logic             r_collision;
  logic [c_AW-1:0]  r_hit_row_out;

  logic             w_busy;
  logic             w_done;
  logic [WIDTH-1:0] w_merge;
  logic             w_row_hit;
  logic             w_start_accept;
  logic             w_last_row;

  cc_row_merge #(.WIDTH(WIDTH)) u_row_merge (
    .point_row (bus.SC_COLLISION_SCAN_pointRow_In),
    .back_row  (bus.SC_COLLISION_SCAN_backRow_In),
    .merge_row (w_merge),
    .hit       (w_row_hit)
  );

  assign w_start_accept = (r_state == ST_IDLE) && bus.SC_COLLISION_SCAN_start_InHigh;
  assign w_last_row     = (r_state == ST_SCAN) && (r_row == c_LAST_ROW);

  always_ff @(posedge SC_COLLISION_SCAN_CLOCK_50 or negedge SC_COLLISION_SCAN_RESET_InLow) begin
    if (!SC_COLLISION_SCAN_RESET_InLow) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Start is only looked at in IDLE, so requests during SCAN/DONE drop on the floor.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.SC_COLLISION_SCAN_start_InHigh) w_state_nxt = ST_SCAN;
      ST_SCAN: if (r_row == c_LAST_ROW)                w_state_nxt = ST_DONE;
      ST_DONE:                                         w_state_nxt = ST_IDLE;
      default:                                         w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      ST_SCAN: w_busy = 1'b1;
      ST_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
        w_done = 1'b0;
      end
    endcase
  end

  always_ff @(posedge SC_COLLISION_SCAN_CLOCK_50 or negedge SC_COLLISION_SCAN_RESET_InLow) begin
    if (!SC_COLLISION_SCAN_RESET_InLow) begin
      r_row <= '0;
    end else if (w_start_accept) begin
      r_row <= '0;
    end else if (r_state == ST_SCAN) begin
      r_row <= (r_row == c_LAST_ROW) ? '0 : r_row + c_ONE;
    end
  end

  always_ff @(posedge SC_COLLISION_SCAN_CLOCK_50 or negedge SC_COLLISION_SCAN_RESET_InLow) begin
    if (!SC_COLLISION_SCAN_RESET_InLow) begin
      r_acc      <= 1'b0;
      r_hit_seen <= 1'b0;
      r_hit_row  <= '0;
    end else if (w_start_accept) begin
      r_acc      <= 1'b0;
      r_hit_seen <= 1'b0;
      r_hit_row  <= '0;
    end else if (r_state == ST_SCAN) begin
      r_acc <= r_acc | w_row_hit;
      if (w_row_hit && !r_hit_seen) begin
        r_hit_row  <= r_row;
        r_hit_seen <= 1'b1;
      end
    end
  end

  always_ff @(posedge SC_COLLISION_SCAN_CLOCK_50 or negedge SC_COLLISION_SCAN_RESET_InLow) begin
    if (!SC_COLLISION_SCAN_RESET_InLow) begin
      r_merge_row   <= '0;
      r_merge_addr  <= '0;
      r_merge_valid <= 1'b0;
    end else if (r_state == ST_SCAN) begin
      r_merge_row   <= w_merge;
      r_merge_addr  <= r_row;
      r_merge_valid <= 1'b1;
    end else begin
      r_merge_valid <= 1'b0;
    end
  end

  // Results commit on the edge that enters DONE, folding in the last row so they
  // line up with the done pulse; they then hold until the next frame completes.
  always_ff @(posedge SC_COLLISION_SCAN_CLOCK_50 or negedge SC_COLLISION_SCAN_RESET_InLow) begin
    if (!SC_COLLISION_SCAN_RESET_InLow) begin
      r_collision   <= 1'b0;
      r_hit_row_out <= '0;
    end else if (w_last_row) begin
      r_collision   <= r_acc | w_row_hit;
      r_hit_row_out <= r_hit_seen ? r_hit_row : (w_row_hit ? r_row : '0);
    end
  end

  assign bus.SC_COLLISION_SCAN_rowAddr_Out    = r_row;
  assign bus.SC_COLLISION_SCAN_mergeRow_Out   = r_merge_row;
  assign bus.SC_COLLISION_SCAN_mergeValid_Out = r_merge_valid;
  assign bus.SC_COLLISION_SCAN_mergeAddr_Out  = r_merge_addr;
  assign bus.SC_COLLISION_SCAN_busy_Out       = w_busy;
  assign bus.SC_COLLISION_SCAN_done_Out       = w_done;
  assign bus.SC_COLLISION_SCAN_collision_Out  = r_collision;
  assign bus.SC_COLLISION_SCAN_hitRow_Out     = r_hit_row_out;

endmodule
`default_nettype wire

// File: tb/tb_sc_collision_scan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sc_collision_scan                                                 |
// | Directed frames against a row-stream scoreboard and a field model.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_sc_collision_scan;

  localparam int ROWS  = 8;
  localparam int WIDTH = 8;
  localparam int AW    = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  sc_collision_scan_if #(.ROWS(ROWS), .WIDTH(WIDTH)) bus ();

  sc_collision_scan #(.ROWS(ROWS), .WIDTH(WIDTH)) dut (
    .SC_COLLISION_SCAN_CLOCK_50    (clk),
    .SC_COLLISION_SCAN_RESET_InLow (rst_n),
    .bus                           (bus)
  );

  logic [WIDTH-1:0] p_mem [ROWS];
  logic [WIDTH-1:0] b_mem [ROWS];

  // The register file answers combinationally at the scanner's row address.
  always_comb begin
    bus.SC_COLLISION_SCAN_pointRow_In = p_mem[bus.SC_COLLISION_SCAN_rowAddr_Out];
    bus.SC_COLLISION_SCAN_backRow_In  = b_mem[bus.SC_COLLISION_SCAN_rowAddr_Out];
  end

  logic             busy, done, mvalid, coll;
  logic [AW-1:0]    row_addr, maddr, hit_row;
  logic [WIDTH-1:0] mrow;
  assign busy     = bus.SC_COLLISION_SCAN_busy_Out;
  assign done     = bus.SC_COLLISION_SCAN_done_Out;
  assign mvalid   = bus.SC_COLLISION_SCAN_mergeValid_Out;
  assign coll     = bus.SC_COLLISION_SCAN_collision_Out;
  assign row_addr = bus.SC_COLLISION_SCAN_rowAddr_Out;
  assign maddr    = bus.SC_COLLISION_SCAN_mergeAddr_Out;
  assign hit_row  = bus.SC_COLLISION_SCAN_hitRow_Out;
  assign mrow     = bus.SC_COLLISION_SCAN_mergeRow_Out;

  int                  checks = 0;
  int                  errors = 0;
  int                  done_cnt = 0;
  logic [AW+WIDTH-1:0] sb [$];
  logic                prev_coll = 1'b0;
  logic [AW-1:0]       prev_hit = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},   32'(busy),     0);
    chk({tag, "_done"},   32'(done),     0);
    chk({tag, "_mvalid"}, 32'(mvalid),   0);
    chk({tag, "_mrow"},   32'(mrow),     0);
    chk({tag, "_maddr"},  32'(maddr),    0);
    chk({tag, "_coll"},   32'(coll),     0);
    chk({tag, "_hit"},    32'(hit_row),  0);
    chk({tag, "_raddr"},  32'(row_addr), 0);
  endtask

  task automatic clear_field();
    for (int r = 0; r < ROWS; r++) begin
      p_mem[r] = '0;
      b_mem[r] = '0;
    end
  endtask

  task automatic model(output logic ec, output logic [AW-1:0] eh);
    ec = 1'b0;
    eh = '0;
    for (int r = 0; r < ROWS; r++) begin
      if ((p_mem[r] & b_mem[r]) != '0) begin
        if (!ec) eh = AW'(r);
        ec = 1'b1;
      end
    end
  endtask

  // Called at a negedge; start is sampled on the next rising edge (edge 0).
  task automatic run_frame(input bit spam);
    logic                ec;
    logic [AW-1:0]       eh;
    logic [AW+WIDTH-1:0] exp_row;
    bit                  seen_done;
    model(ec, eh);
    for (int r = 0; r < ROWS; r++) sb.push_back({AW'(r), p_mem[r] | b_mem[r]});
    bus.SC_COLLISION_SCAN_start_InHigh = 1'b1;
    seen_done = 1'b0;
    for (int k = 1; k <= 20 && !seen_done; k++) begin
      @(negedge clk);
      bus.SC_COLLISION_SCAN_start_InHigh = spam && (k == 1 || k == 4 || k == ROWS + 1);
      chk("busy",     32'(busy),     32'(k <= ROWS + 1));
      chk("mvalid",   32'(mvalid),   32'(k >= 2 && k <= ROWS + 1));
      chk("row_addr", 32'(row_addr), (k <= ROWS) ? 32'(k - 1) : 0);
      if (mvalid) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_row = sb.pop_front();
          chk("merge_addr_row", 32'({maddr, mrow}), 32'(exp_row));
        end
      end
      if (done) begin
        done_cnt++;
        seen_done = 1'b1;
        chk("done_cycle", k,               ROWS + 1);
        chk("collision",  32'(coll),       32'(ec));
        chk("hit_row",    32'(hit_row),    32'(eh));
        chk("sb_drained", sb.size(),       0);
        prev_coll = ec;
        prev_hit  = eh;
      end else begin
        chk("hold_coll", 32'(coll),    32'(prev_coll));
        chk("hold_hit",  32'(hit_row), 32'(prev_hit));
      end
    end
    chk("done_seen", 32'(seen_done), 1);
  endtask

  initial begin
    bus.SC_COLLISION_SCAN_start_InHigh = 1'b0;
    clear_field();
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Empty field, started on the first edge after reset release.
    run_frame(1'b0);
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);

    // Frog on a background block at row 3.
    p_mem[3] = 8'h10;
    b_mem[3] = 8'h18;
    run_frame(1'b0);
    @(negedge clk);

    // Two colliding rows plus non-colliding clutter; lowest row must win.
    clear_field();
    p_mem[2] = 8'h81; b_mem[2] = 8'h01;
    p_mem[6] = 8'h40; b_mem[6] = 8'hC0;
    b_mem[0] = 8'h0F; p_mem[1] = 8'hF0;
    run_frame(1'b0);

    // Back-to-back: clean frame must not inherit the previous accumulator.
    @(negedge clk);
    clear_field();
    p_mem[4] = 8'hAA; b_mem[4] = 8'h55;
    run_frame(1'b0);

    // Back-to-back again, collision only on the last row.
    @(negedge clk);
    p_mem[7] = 8'h01; b_mem[7] = 8'h01;
    run_frame(1'b0);
    @(negedge clk);

    // Start pulses mid-scan and in DONE are dropped; collision on row 0.
    clear_field();
    p_mem[0] = 8'h80; b_mem[0] = 8'h80;
    done_cnt = 0;
    run_frame(1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.SC_COLLISION_SCAN_start_InHigh = 1'b0;
      chk("no_restart_busy", 32'(busy), 0);
    end
    chk("done_pulses", done_cnt, 1);

    // Asynchronous reset in the middle of a colliding scan.
    clear_field();
    p_mem[1] = 8'h02; b_mem[1] = 8'h02;
    p_mem[5] = 8'h20; b_mem[5] = 8'h20;
    bus.SC_COLLISION_SCAN_start_InHigh = 1'b1;
    @(negedge clk);
    bus.SC_COLLISION_SCAN_start_InHigh = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_reset_row", 32'(row_addr), 5);
    chk("pre_reset_mvalid", 32'(mvalid), 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    sb.delete();
    @(negedge clk);
    chk_all_zero("held_rst");
    rst_n     = 1'b1;
    prev_coll = 1'b0;
    prev_hit  = '0;

    // Clean frame after the aborted one.
    clear_field();
    b_mem[5] = 8'hFF;
    run_frame(1'b0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
